frame_buf_reader: RTL and testbench
===================================

Name: frame_buf_reader

Overview:
- Single-clock read-side engine that drains one complete frame from the frame-buffer data memory.
- Issues sequential read requests to the memory and absorbs its variable read latency via `mem_rd_data_valid`.
- Buffers returned words in a small FIFO and presents them as a valid/ready pixel stream with start-of-frame and end-of-line markers.
- Sits between the frame-buffer memory and the downstream display/encoder pipeline.

Parameters:
- DATA_WIDTH, 32, pixel/memory word width
- ADDR_WIDTH, 8, memory address width
- FRAME_LEN, 1 << ADDR_WIDTH, words per frame (2..2^ADDR_WIDTH)
- LINE_LEN, 16, words per line; FRAME_LEN must be a multiple of LINE_LEN
- FIFO_DEPTH, 4, return-buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start_l  in  1  active-low frame start request
- frame_rdy  in  1  writer has a complete frame in memory
- mem_rd_en_l  out  1  active-low memory read strobe
- mem_rd_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  memory read data
- mem_rd_data_valid  in  1  mem_rd_data valid this cycle
- pix_data  out  DATA_WIDTH  output pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts pixel
- pix_sof  out  1  qualifies first pixel of frame
- pix_eol  out  1  qualifies last pixel of each line
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when frame fully delivered
- err  out  1  sticky: data_valid with zero outstanding reads

Behaviour:
- Reset (async, active-low): state IDLE. Outputs:
  - mem_rd_en_l=1, mem_rd_addr=0
  - pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0
  - busy=0, done=0, err=0
  - FIFO empty; outstanding=0; pixel counters 0.
- States IDLE, FETCH, DRAIN (2-bit encoding).
- IDLE:
  - Goes to FETCH when start_l==0 && frame_rdy==1; sets busy=1 and rd_addr=0 on that edge.
  - Otherwise stays; mem_rd_en_l=1.
- FETCH, read issue:
  - mem_rd_en_l=0 for a cycle iff (outstanding + fifo_count) < FIFO_DEPTH (credit rule); mem_rd_addr=rd_addr that cycle.
  - Each issue increments rd_addr.
  - Issue at rd_addr==FRAME_LEN-1 is the last; no wrap. Next state DRAIN.
- outstanding counter:
  - +1 on issue, −1 on mem_rd_data_valid; simultaneous = no change.
  - Width clog2(FIFO_DEPTH)+1.
- Returns and FIFO:
  - Every mem_rd_data_valid with outstanding>0 pushes mem_rd_data into the FIFO.
  - With outstanding==0: data dropped, err set (cleared only by reset).
  - Credit rule makes FIFO overflow impossible; simultaneous push/pop keeps count.
- Output:
  - pix_valid = FIFO not empty; pix_data = FIFO head.
  - Pop on pix_valid && pix_ready.
  - pix_data is held stable while pix_valid && !pix_ready.
- Markers:
  - Output pixel counter pix_idx counts popped pixels; line counter col wraps at LINE_LEN-1.
  - pix_sof = pix_valid && pix_idx==0.
  - pix_eol = pix_valid && col==LINE_LEN-1.
- DRAIN: no reads issued. When outstanding==0 && FIFO empty, pulse done=1 for one cycle, busy=0, return to IDLE, clear counters.
- start_l while busy: ignored. frame_rdy dropping mid-frame: ignored.
- Minimum latency: start_l sampled → first mem_rd_en_l low next cycle. Steady-state throughput is 1 pixel/clock with pix_ready held high and memory latency ≤ FIFO_DEPTH−1.
- Reset mid-frame: immediate return to reset values. Returns arriving afterwards set err only if they arrive with outstanding==0.

Decomposition:
- Shared include:
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H macros
  - reader state encodings (IDLE, FETCH, DRAIN)
  - clog2 constant function
- One sub-module: pix_fifo.
  - Single-clock FIFO, parameters DATA_WIDTH and FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, empty.
  - Asynchronous active-low reset.

Test Plan:
- Basic frame: FRAME_LEN=32, LINE_LEN=8, memory latency 1, pix_ready=1, memory returns word==addr.
  - Expect pix_data 0..31 in order, 1/clock.
  - pix_sof only on 0; pix_eol on 7, 15, 23, 31.
  - done pulse once, then busy=0.
- Backpressure: toggle pix_ready 1/0 every cycle.
  - No pixel lost or duplicated; pix_data stable while stalled.
  - mem_rd_en_l never low when outstanding+fifo_count==4.
- Long latency: memory latency 6 with FIFO_DEPTH=4.
  - At most 4 reads outstanding.
  - All 32 words delivered in order; done after last pop.
- Start gating:
  - start_l=0 with frame_rdy=0 → stays IDLE, no reads.
  - Second start_l pulse mid-frame → ignored; single done.
- Reset mid-frame: assert reset after pixel 10.
  - All outputs return to reset values asynchronously.
  - Restart delivers 0..31 with pix_sof on pixel 0.
- Spurious return: mem_rd_data_valid pulse in IDLE → err=1 and remains 1; stream unaffected.

Source files
------------

// File: rtl/frame_buf_reader_pkg.sv
// ----------------------------------------------------------------------------
// frame_buf_reader_pkg
// Shared constants for the frame-buffer read engine:
//   - active-low / active-high assert and deassert levels
//   - reader state encodings (IDLE, FETCH, DRAIN), 2-bit
//   - clog2 constant function used for counter and pointer widths
// ----------------------------------------------------------------------------
package frame_buf_reader_pkg;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_buf_reader_if.sv
// ----------------------------------------------------------------------------
// frame_buf_reader_if
// Groups the memory read bus and the outgoing pixel stream.
//   master : the reader (drives read strobe/address and pixel stream)
//   slave  : memory + downstream sink (drives read data and pix_ready)
// Signals:
//   mem_rd_en_l, mem_rd_addr          read request (active-low strobe)
//   mem_rd_data, mem_rd_data_valid    read return, variable latency
//   pix_data, pix_valid, pix_ready    valid/ready pixel stream
//   pix_sof, pix_eol                  start-of-frame / end-of-line markers
// ----------------------------------------------------------------------------
interface frame_buf_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_rd_en_l;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_data_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic                  pix_eol;

    modport master (
        output mem_rd_en_l, mem_rd_addr,
        input  mem_rd_data, mem_rd_data_valid,
        output pix_data, pix_valid, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en_l, mem_rd_addr,
        output mem_rd_data, mem_rd_data_valid,
        input  pix_data, pix_valid, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/frame_buf_reader_pix_fifo.sv
// ----------------------------------------------------------------------------
// pix_fifo
// Single-clock return buffer between the memory and the pixel stream.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push, din    write a word (caller guarantees not full)
//   pop          read the head word (ignored when empty)
//   dout         head word, valid whenever !empty
//   count        number of stored words (0..FIFO_DEPTH)
//   empty        no words stored
// ----------------------------------------------------------------------------
module pix_fifo
    import frame_buf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        din,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [clog2(FIFO_DEPTH):0]   count,
    output logic                         empty
);
    localparam int PW = clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    // Storage is cleared on reset so the head word reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/frame_buf_reader.sv
// ----------------------------------------------------------------------------
// frame_buf_reader
// Drains one complete frame from frame-buffer memory and presents it as a
// valid/ready pixel stream with start-of-frame and end-of-line markers.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start_l        active-low frame start request (honoured only when idle)
//   frame_rdy      writer has a complete frame in memory
//   bus (master)   memory read bus + pixel stream
//   busy           frame in progress
//   done           one-cycle pulse after the last pixel has been delivered
//   err            sticky: read data returned with no read outstanding
// ----------------------------------------------------------------------------
module frame_buf_reader
    import frame_buf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 1 << ADDR_WIDTH,
    parameter int LINE_LEN   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_l,
    input  logic                frame_rdy,
    frame_buf_reader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int OW = clog2(FIFO_DEPTH) + 1;
    localparam int CW = (LINE_LEN > 1) ? clog2(LINE_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [CW-1:0]         LAST_COL  = CW'(LINE_LEN - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [ADDR_WIDTH-1:0] pix_idx;
    logic [CW-1:0]         col;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  start_go;
    logic                  frame_end;

    // Every in-flight read already owns a FIFO slot, so the FIFO can never
    // overflow no matter how the memory latency varies.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (OW + 1)'(FIFO_DEPTH);
    assign issue     = (state == ST_FETCH) && credit_ok;
    assign push      = bus.mem_rd_data_valid && (outstanding != '0);
    assign pop       = !fifo_empty && bus.pix_ready;
    assign start_go  = (state == ST_IDLE) && (start_l == ASSERT_L) && (frame_rdy == ASSERT_H);
    assign frame_end = (state == ST_DRAIN) && (outstanding == '0) && fifo_empty;

    assign bus.mem_rd_en_l = issue ? ASSERT_L : DEASSERT_L;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.pix_valid   = !fifo_empty;
    assign bus.pix_data    = fifo_dout;
    assign bus.pix_sof     = !fifo_empty && (pix_idx == '0);
    assign bus.pix_eol     = !fifo_empty && (col == LAST_COL);

    pix_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.mem_rd_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Reader FSM: the last read parks rd_addr at LAST_ADDR (no wrap) until
    // the frame completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
            busy    <= DEASSERT_H;
            done    <= DEASSERT_H;
        end else begin
            done <= DEASSERT_H;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        state   <= ST_FETCH;
                        busy    <= ASSERT_H;
                        rd_addr <= '0;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (frame_end) begin
                        state   <= ST_IDLE;
                        busy    <= DEASSERT_H;
                        done    <= ASSERT_H;
                        rd_addr <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding reads only move on accepted returns; a return with nothing
    // outstanding is dropped and latched as an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            err         <= DEASSERT_H;
        end else begin
            case ({issue, push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (bus.mem_rd_data_valid && (outstanding == '0)) begin
                err <= ASSERT_H;
            end
        end
    end

    // Marker counters track popped pixels within the frame and the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_idx <= '0;
            col     <= '0;
        end else if (start_go || frame_end) begin
            pix_idx <= '0;
            col     <= '0;
        end else if (pop) begin
            pix_idx <= pix_idx + 1'b1;
            col     <= (col == LAST_COL) ? '0 : col + 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_buf_reader.sv
module tb_frame_buf_reader;

    logic clk = 1'b0;
    logic reset;
    logic start_l;
    logic frame_rdy;
    logic busy;
    logic done;
    logic err;

    frame_buf_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bif ();

    frame_buf_reader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .FRAME_LEN  (32),
        .LINE_LEN   (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_l   (start_l),
        .frame_rdy (frame_rdy),
        .bus       (bif),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // memory model: returns word == address after 'lat' cycles
    bit          sched_v [16];
    logic [31:0] sched_d [16];
    int lat;
    bit bp_mode;
    bit inject;

    // scoreboard state
    int exp_idx;
    int exp_addr;
    int issued;
    int popped;
    int done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic clear_mem_model();
        for (int i = 0; i < 16; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = '0;
        end
        bif.mem_rd_data_valid = 1'b0;
        bif.mem_rd_data       = '0;
    endtask

    // One cycle: at the falling edge observe outputs, then drive inputs for
    // the next rising edge.
    task automatic step();
        bit issue_now;
        bit pop_now;
        logic [7:0] a;
        @(negedge clk);
        if (bp_mode) bif.pix_ready = ~bif.pix_ready;
        else         bif.pix_ready = 1'b1;
        pop_now = 1'b0;
        if (bif.pix_valid === 1'b1) begin
            check("pix_data", bif.pix_data, 64'(exp_idx));
            check("pix_sof", bif.pix_sof, 64'(exp_idx == 0));
            check("pix_eol", bif.pix_eol, 64'((exp_idx % 8) == 7));
            pop_now = bif.pix_ready;
        end
        issue_now = (bif.mem_rd_en_l === 1'b0);
        a = bif.mem_rd_addr;
        if (issue_now) begin
            check("rd_addr", a, 64'(exp_addr));
            check("credit", 64'((issued - popped) < 4), 64'd1);
            issued++;
            exp_addr++;
        end
        bif.mem_rd_data_valid = sched_v[0];
        bif.mem_rd_data       = sched_d[0];
        for (int i = 0; i < 15; i++) begin
            sched_v[i] = sched_v[i+1];
            sched_d[i] = sched_d[i+1];
        end
        sched_v[15] = 1'b0;
        if (issue_now) begin
            sched_v[lat-1] = 1'b1;
            sched_d[lat-1] = {24'd0, a};
        end
        if (inject) begin
            bif.mem_rd_data_valid = 1'b1;
            bif.mem_rd_data       = 32'hDEAD_BEEF;
        end
        if (reset === 1'b0) clear_mem_model();
        if (pop_now) begin
            popped++;
            exp_idx++;
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic new_frame_vars();
        exp_idx  = 0;
        exp_addr = 0;
        issued   = 0;
        popped   = 0;
        done_cnt = 0;
    endtask

    task automatic run_frame(input int lat_i, input bit bp, input int restart_at,
                             input bit exp_err, input int max_cyc);
        int cyc;
        lat     = lat_i;
        bp_mode = bp;
        new_frame_vars();
        start_l = 1'b0;
        step();
        start_l = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < max_cyc) begin
            start_l = (cyc == restart_at) ? 1'b0 : 1'b1;
            step();
            if (cyc == 0) check("busy_run", busy, 1);
            cyc++;
        end
        start_l = 1'b1;
        check("done_seen", 64'(done_cnt), 64'd1);
        check("pixels", 64'(exp_idx), 64'd32);
        check("reads", 64'(issued), 64'd32);
        check("busy_at_done", busy, 0);
        step();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("single_done", 64'(done_cnt), 64'd1);
        check("err_state", err, 64'(exp_err));
        bp_mode = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start_l   = 1'b1;
        frame_rdy = 1'b1;
        lat       = 1;
        bp_mode   = 1'b0;
        inject    = 1'b0;
        bif.pix_ready = 1'b1;
        clear_mem_model();
        new_frame_vars();
        step();
        step();
        check("rst_rd_en_l", bif.mem_rd_en_l, 1);
        check("rst_addr", bif.mem_rd_addr, 0);
        check("rst_pix_valid", bif.pix_valid, 0);
        check("rst_sof", bif.pix_sof, 0);
        check("rst_eol", bif.pix_eol, 0);
        check("rst_pix_data", bif.pix_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        step();

        // basic frame at 1 pixel/clock, stray start mid-frame ignored
        run_frame(1, 1'b0, 10, 1'b0, 40);
        // backpressure
        run_frame(1, 1'b1, -1, 1'b0, 200);
        // long memory latency
        run_frame(6, 1'b0, -1, 1'b0, 300);

        // start without a ready frame must not start reading
        frame_rdy = 1'b0;
        start_l   = 1'b0;
        new_frame_vars();
        for (int i = 0; i < 5; i++) begin
            step();
            check("gate_rd_en_l", bif.mem_rd_en_l, 1);
            check("gate_busy", busy, 0);
        end
        check("gate_reads", 64'(issued), 64'd0);
        start_l   = 1'b1;
        frame_rdy = 1'b1;
        step();

        // reset mid-frame after pixel 10
        lat = 1;
        new_frame_vars();
        start_l = 1'b0;
        step();
        start_l = 1'b1;
        for (int i = 0; i < 200 && exp_idx < 11; i++) step();
        check("mid_pixels", 64'(exp_idx), 64'd11);
        #1;
        reset = 1'b0;
        clear_mem_model();
        #1;
        check("mid_rd_en_l", bif.mem_rd_en_l, 1);
        check("mid_addr", bif.mem_rd_addr, 0);
        check("mid_pix_valid", bif.pix_valid, 0);
        check("mid_sof", bif.pix_sof, 0);
        check("mid_eol", bif.pix_eol, 0);
        check("mid_pix_data", bif.pix_data, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        step();
        step();
        reset = 1'b1;
        step();
        run_frame(1, 1'b0, -1, 1'b0, 40);

        // spurious return while idle sets the sticky error
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        check("spur_err", err, 1);
        step();
        check("spur_err_hold", err, 1);
        run_frame(1, 1'b0, -1, 1'b1, 40);
        check("spur_err_end", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
